// File: rtl/riscv_dm_pkg.sv
// Shared definitions for the debug-module run-control path.
// Contents:
//   - DMI register addresses used by the hart array (dm_reg_t)
//   - DMCONTROL / DMSTATUS register layouts (dmcontrol_t, dmstatus_t)
//   - per-hart status bundle reduced into DMSTATUS (hart_status_t)
//   - sizing constants for hartsel and the hart-array window
package riscv_dm_pkg;

    localparam int         HARTSEL_MAX_LEN  = 20;
    localparam int         HAWINDOW_GROUP_W = 32;
    localparam logic [3:0] DMSTATUS_VERSION = 4'd3;

    typedef enum logic [6:0] {
        DM_DMCONTROL   = 7'h10,
        DM_DMSTATUS    = 7'h11,
        DM_HAWINDOWSEL = 7'h14,
        DM_HAWINDOW    = 7'h15
    } dm_reg_t;

    typedef struct packed {
        logic       halted;
        logic       running;
        logic       unavail;
        logic       havereset;
        logic       resumeack;
    } hart_status_t;

    typedef struct packed {
        logic       haltreq;
        logic       resumereq;
        logic       hartreset;
        logic       ackhavereset;
        logic       ackunavail;
        logic       hasel;
        logic [9:0] hartsello;
        logic [9:0] hartselhi;
        logic       setkeepalive;
        logic       clrkeepalive;
        logic       setresethaltreq;
        logic       clrresethaltreq;
        logic       ndmreset;
        logic       dmactive;
    } dmcontrol_t;

    typedef struct packed {
        logic [6:0] zero1;
        logic       ndmresetpending;
        logic       stickyunavail;
        logic       impebreak;
        logic [1:0] zero0;
        logic       allhavereset;
        logic       anyhavereset;
        logic       allresumeack;
        logic       anyresumeack;
        logic       allnonexistent;
        logic       anynonexistent;
        logic       allunavail;
        logic       anyunavail;
        logic       allrunning;
        logic       anyrunning;
        logic       allhalted;
        logic       anyhalted;
        logic       authenticated;
        logic       authbusy;
        logic       hasresethaltreq;
        logic       confstrptrvalid;
        logic [3:0] version;
    } dmstatus_t;

endpackage

// File: rtl/riscv_dm_hart_reduce.sv
// Any/all reduction of per-hart status over a selection mask.
// Ports:
//   sel_i    - one bit per hart, 1 = hart takes part in the reduction
//   status_i - per-hart status bundle
//   any_o    - field-wise OR over selected harts (0 when none selected)
//   all_o    - field-wise AND over selected harts (1 when none selected;
//              the caller decides what an empty selection reports)
module riscv_dm_hart_reduce
    import riscv_dm_pkg::*;
#(
    parameter int NUM_HARTS = 1
) (
    input  logic         [NUM_HARTS-1:0] sel_i,
    input  hart_status_t [NUM_HARTS-1:0] status_i,
    output hart_status_t                 any_o,
    output hart_status_t                 all_o
);

    hart_status_t [NUM_HARTS-1:0] any_terms;
    hart_status_t [NUM_HARTS-1:0] all_terms;

    // Unselected harts contribute the identity element of each reduction.
    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_term
        assign any_terms[gi] = sel_i[gi] ? status_i[gi] : '0;
        assign all_terms[gi] = sel_i[gi] ? status_i[gi] : '1;
    end

    always_comb begin
        any_o = '0;
        all_o = '1;
        for (int i = 0; i < NUM_HARTS; i++) begin
            any_o = any_o | any_terms[i];
            all_o = all_o & all_terms[i];
        end
    end

endmodule

// File: rtl/riscv_dm_hart_array.sv
// Multi-hart run control for the debug module.
// Decodes DMI writes to DMCONTROL, HAWINDOWSEL and HAWINDOW, drives
// per-hart haltreq/resumereq/hartreset, keeps sticky havereset/resumeack
// per hart and produces a registered, aggregated DMSTATUS over the
// selected hart set (hartsel plus optional hart-array window mask).
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   wr_en_i/wr_addr_i/wr_data_i       one-cycle DMI write
//   dmcontrol_o                       DMCONTROL readback (W1 fields read 0)
//   dmstatus_o                        aggregated DMSTATUS, registered
//   hawindowsel_o / hawindow_o        current window group / its mask bits
//   ndmreset_o, dmactive_o            global control bits
//   halted_i/running_i/unavail_i      per-hart status levels
//   havereset_i/resumeack_i           per-hart event pulses
//   haltreq_o/resumereq_o/hartreset_o per-hart request levels
module riscv_dm_hart_array
    import riscv_dm_pkg::*;
#(
    parameter int NUM_HARTS   = 1,
    parameter int HARTSEL_LEN = ($clog2(NUM_HARTS) > 0) ? $clog2(NUM_HARTS) : 1,
    parameter bit HASEL_EN    = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [6:0]           wr_addr_i,
    input  logic [31:0]          wr_data_i,
    output logic [31:0]          dmcontrol_o,
    output logic [31:0]          dmstatus_o,
    output logic [31:0]          hawindowsel_o,
    output logic [31:0]          hawindow_o,
    output logic                 ndmreset_o,
    output logic                 dmactive_o,
    input  logic [NUM_HARTS-1:0] halted_i,
    input  logic [NUM_HARTS-1:0] running_i,
    input  logic [NUM_HARTS-1:0] unavail_i,
    input  logic [NUM_HARTS-1:0] havereset_i,
    input  logic [NUM_HARTS-1:0] resumeack_i,
    output logic [NUM_HARTS-1:0] haltreq_o,
    output logic [NUM_HARTS-1:0] resumereq_o,
    output logic [NUM_HARTS-1:0] hartreset_o
);

    localparam int NUM_GROUPS = (NUM_HARTS + HAWINDOW_GROUP_W - 1) / HAWINDOW_GROUP_W;
    localparam int GROUP_W    = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int MASK_W     = NUM_GROUPS * HAWINDOW_GROUP_W;

    // ---------------- state ----------------
    logic                   dmactive_q,  dmactive_d;
    logic                   ndmreset_q,  ndmreset_d;
    logic                   hasel_q,     hasel_d;
    logic [HARTSEL_LEN-1:0] hartsel_q,   hartsel_d;
    logic [GROUP_W-1:0]     group_q,     group_d;
    logic [MASK_W-1:0]      mask_q,      mask_d;
    logic [NUM_HARTS-1:0]   haltreq_q,   haltreq_d;
    logic [NUM_HARTS-1:0]   resumereq_q, resumereq_d;
    logic [NUM_HARTS-1:0]   hartreset_q, hartreset_d;
    logic [NUM_HARTS-1:0]   havereset_q, havereset_d;
    logic [NUM_HARTS-1:0]   resumeack_q, resumeack_d;
    dmstatus_t              dmstatus_q,  dmstatus_d;

    // ---------------- write decode ----------------
    dmcontrol_t                 wr_ctrl;
    logic [HARTSEL_MAX_LEN-1:0] wr_hartsel_full;
    logic [HARTSEL_LEN-1:0]     wr_hartsel;
    logic                       ctrl_wr, ctrl_clear, ctrl_activate, ctrl_full;
    logic                       hwsel_wr, hw_wr;
    logic                       unused_wr_bits;

    assign wr_ctrl         = dmcontrol_t'(wr_data_i);
    assign wr_hartsel_full = {wr_ctrl.hartselhi, wr_ctrl.hartsello};
    assign wr_hartsel      = wr_hartsel_full[HARTSEL_LEN-1:0];
    assign unused_wr_bits  = ^{wr_hartsel_full, wr_ctrl.ackunavail, wr_ctrl.setkeepalive,
                               wr_ctrl.clrkeepalive, wr_ctrl.setresethaltreq,
                               wr_ctrl.clrresethaltreq};

    assign ctrl_wr       = wr_en_i && (wr_addr_i == DM_DMCONTROL);
    // dmactive=0 acts as a soft reset; while inactive only dmactive can be set.
    assign ctrl_clear    = ctrl_wr && !wr_ctrl.dmactive;
    assign ctrl_activate = ctrl_wr &&  wr_ctrl.dmactive && !dmactive_q;
    assign ctrl_full     = ctrl_wr &&  wr_ctrl.dmactive &&  dmactive_q;
    assign hwsel_wr      = HASEL_EN && dmactive_q && wr_en_i && (wr_addr_i == DM_HAWINDOWSEL);
    assign hw_wr         = HASEL_EN && dmactive_q && wr_en_i && (wr_addr_i == DM_HAWINDOW);

    // ---------------- hart selection ----------------
    // wr_sel: set addressed by the DMCONTROL value being written.
    // cur_sel: set addressed by the stored hartsel/hasel, used for status.
    logic [NUM_HARTS-1:0] wr_sel, cur_sel;
    logic                 hartsel_exists;

    assign hartsel_exists = (32'(hartsel_q) < 32'(NUM_HARTS));

    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_sel
        assign wr_sel[gi]  = (32'(wr_hartsel) == gi) || (HASEL_EN && wr_ctrl.hasel && mask_q[gi]);
        assign cur_sel[gi] = (32'(hartsel_q)  == gi) || (hasel_q && mask_q[gi]);
    end

    // ---------------- global next state ----------------
    always_comb begin
        dmactive_d = dmactive_q;
        ndmreset_d = ndmreset_q;
        hasel_d    = hasel_q;
        hartsel_d  = hartsel_q;
        group_d    = group_q;
        mask_d     = mask_q;

        if (ctrl_clear) begin
            dmactive_d = 1'b0;
            ndmreset_d = 1'b0;
            hasel_d    = 1'b0;
            hartsel_d  = '0;
            group_d    = '0;
            mask_d     = '0;
        end else if (ctrl_activate) begin
            dmactive_d = 1'b1;
        end else if (ctrl_full) begin
            ndmreset_d = wr_ctrl.ndmreset;
            hasel_d    = HASEL_EN && wr_ctrl.hasel;
            hartsel_d  = wr_hartsel;
        end

        if (hwsel_wr) begin
            if (wr_data_i >= 32'(NUM_GROUPS - 1)) begin
                group_d = GROUP_W'(NUM_GROUPS - 1);
            end else begin
                group_d = wr_data_i[GROUP_W-1:0];
            end
        end

        if (hw_wr) begin
            mask_d[int'(group_q) * HAWINDOW_GROUP_W +: HAWINDOW_GROUP_W] = wr_data_i;
        end

        // Window bits beyond the last hart never hold state.
        for (int i = NUM_HARTS; i < MASK_W; i++) begin
            mask_d[i] = 1'b0;
        end
    end

    // ---------------- per-hart next state ----------------
    always_comb begin
        haltreq_d   = haltreq_q;
        resumereq_d = resumereq_q;
        hartreset_d = hartreset_q;
        havereset_d = havereset_q | havereset_i;
        resumeack_d = resumeack_q;

        for (int i = 0; i < NUM_HARTS; i++) begin
            if (resumereq_q[i] && resumeack_i[i]) begin
                resumereq_d[i] = 1'b0;
                resumeack_d[i] = 1'b1;
            end

            if (ctrl_clear) begin
                haltreq_d[i]   = 1'b0;
                resumereq_d[i] = 1'b0;
                hartreset_d[i] = 1'b0;
                resumeack_d[i] = 1'b0;
            end else if (ctrl_full && wr_sel[i]) begin
                haltreq_d[i]   = wr_ctrl.haltreq;
                hartreset_d[i] = wr_ctrl.hartreset;
                // A fresh resume overrides a same-cycle ack of the old one.
                if (wr_ctrl.resumereq && !wr_ctrl.haltreq && halted_i[i]) begin
                    resumereq_d[i] = 1'b1;
                    resumeack_d[i] = 1'b0;
                end
                if (wr_ctrl.ackhavereset && !havereset_i[i]) begin
                    havereset_d[i] = 1'b0;
                end
            end
        end
    end

    // ---------------- status aggregation ----------------
    hart_status_t [NUM_HARTS-1:0] hart_status;
    hart_status_t                 any_s, all_s;
    logic                         none_sel;

    for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_status
        assign hart_status[gi] = {halted_i[gi], running_i[gi], unavail_i[gi],
                                  havereset_q[gi], resumeack_q[gi]};
    end

    riscv_dm_hart_reduce #(
        .NUM_HARTS (NUM_HARTS)
    ) u_reduce (
        .sel_i    (cur_sel),
        .status_i (hart_status),
        .any_o    (any_s),
        .all_o    (all_s)
    );

    assign none_sel = ~|cur_sel;

    always_comb begin
        dmstatus_d                = '0;
        dmstatus_d.version        = DMSTATUS_VERSION;
        dmstatus_d.authenticated  = 1'b1;
        dmstatus_d.anynonexistent = !hartsel_exists;
        dmstatus_d.allnonexistent = none_sel;
        // An empty selection reports nothing but nonexistence.
        if (!none_sel) begin
            dmstatus_d.anyhalted    = any_s.halted;
            dmstatus_d.allhalted    = all_s.halted;
            dmstatus_d.anyrunning   = any_s.running;
            dmstatus_d.allrunning   = all_s.running;
            dmstatus_d.anyunavail   = any_s.unavail;
            dmstatus_d.allunavail   = all_s.unavail;
            dmstatus_d.anyhavereset = any_s.havereset;
            dmstatus_d.allhavereset = all_s.havereset;
            dmstatus_d.anyresumeack = any_s.resumeack;
            dmstatus_d.allresumeack = all_s.resumeack;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dmactive_q  <= 1'b0;
            ndmreset_q  <= 1'b0;
            hasel_q     <= 1'b0;
            hartsel_q   <= '0;
            group_q     <= '0;
            mask_q      <= '0;
            haltreq_q   <= '0;
            resumereq_q <= '0;
            hartreset_q <= '0;
            havereset_q <= '1;
            resumeack_q <= '0;
            dmstatus_q  <= '0;
        end else begin
            dmactive_q  <= dmactive_d;
            ndmreset_q  <= ndmreset_d;
            hasel_q     <= hasel_d;
            hartsel_q   <= hartsel_d;
            group_q     <= group_d;
            mask_q      <= mask_d;
            haltreq_q   <= haltreq_d;
            resumereq_q <= resumereq_d;
            hartreset_q <= hartreset_d;
            havereset_q <= havereset_d;
            resumeack_q <= resumeack_d;
            dmstatus_q  <= dmstatus_d;
        end
    end

    // ---------------- outputs ----------------
    dmcontrol_t                 ctrl_rd;
    logic [HARTSEL_MAX_LEN-1:0] hartsel_full;

    assign hartsel_full = HARTSEL_MAX_LEN'(hartsel_q);

    always_comb begin
        ctrl_rd           = '0;
        ctrl_rd.hasel     = hasel_q;
        ctrl_rd.hartsello = hartsel_full[9:0];
        ctrl_rd.hartselhi = hartsel_full[19:10];
        ctrl_rd.ndmreset  = ndmreset_q;
        ctrl_rd.dmactive  = dmactive_q;
    end

    assign dmcontrol_o   = ctrl_rd;
    assign dmstatus_o    = dmstatus_q;
    assign hawindowsel_o = 32'(group_q);
    assign hawindow_o    = mask_q[int'(group_q) * HAWINDOW_GROUP_W +: HAWINDOW_GROUP_W];
    assign ndmreset_o    = ndmreset_q;
    assign dmactive_o    = dmactive_q;
    assign haltreq_o     = haltreq_q;
    assign resumereq_o   = resumereq_q;
    assign hartreset_o   = hartreset_q;

endmodule

// File: tb/tb_riscv_dm_hart_array.sv
module tb_riscv_dm_hart_array;

    localparam int NH = 4;

    localparam logic [6:0] A_CTRL  = 7'h10;
    localparam logic [6:0] A_HWSEL = 7'h14;
    localparam logic [6:0] A_HW    = 7'h15;

    localparam int S_DMSTATUS  = 0;
    localparam int S_HALTREQ   = 1;
    localparam int S_RESUMEREQ = 2;
    localparam int S_HARTRESET = 3;
    localparam int S_HAWINDOW  = 4;
    localparam int S_DMCONTROL = 5;
    localparam int S_HWSEL     = 6;
    localparam int S_NDMRESET  = 7;
    localparam int S_DMACTIVE  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [6:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   dmcontrol, dmstatus, hawindowsel, hawindow;
    logic          ndmreset, dmactive;
    logic [NH-1:0] halted, running, unavail, havereset_p, resumeack_p;
    logic [NH-1:0] haltreq, resumereq, hartreset;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          sig;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    riscv_dm_hart_array #(
        .NUM_HARTS   (NH),
        .HARTSEL_LEN (3),
        .HASEL_EN    (1'b1)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .dmcontrol_o   (dmcontrol),
        .dmstatus_o    (dmstatus),
        .hawindowsel_o (hawindowsel),
        .hawindow_o    (hawindow),
        .ndmreset_o    (ndmreset),
        .dmactive_o    (dmactive),
        .halted_i      (halted),
        .running_i     (running),
        .unavail_i     (unavail),
        .havereset_i   (havereset_p),
        .resumeack_i   (resumeack_p),
        .haltreq_o     (haltreq),
        .resumereq_o   (resumereq),
        .hartreset_o   (hartreset)
    );

    // Expected DMSTATUS word built from the architectural bit positions.
    function automatic logic [31:0] ds(input bit anyh, input bit allh,
                                       input bit anyr, input bit allr,
                                       input bit anyu, input bit allu,
                                       input bit anynx, input bit allnx,
                                       input bit anyra, input bit allra,
                                       input bit anyhr, input bit allhr);
        logic [31:0] v;
        v     = 32'h0000_0083;
        v[8]  = anyh;  v[9]  = allh;
        v[10] = anyr;  v[11] = allr;
        v[12] = anyu;  v[13] = allu;
        v[14] = anynx; v[15] = allnx;
        v[16] = anyra; v[17] = allra;
        v[18] = anyhr; v[19] = allhr;
        return v;
    endfunction

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_DMSTATUS:  return dmstatus;
            S_HALTREQ:   return 32'(haltreq);
            S_RESUMEREQ: return 32'(resumereq);
            S_HARTRESET: return 32'(hartreset);
            S_HAWINDOW:  return hawindow;
            S_DMCONTROL: return dmcontrol;
            S_HWSEL:     return hawindowsel;
            S_NDMRESET:  return 32'(ndmreset);
            S_DMACTIVE:  return 32'(dmactive);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input int sig, input logic [31:0] exp, input string tag);
        sb.push_back('{sig, exp, tag});
    endtask

    // Pops every queued expectation and compares it with the live output.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sig);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
            $display("check %-16s observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(input logic [6:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        cyc();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        halted = '0; running = '0; unavail = '0; havereset_p = '0; resumeack_p = '0;

        // Reset state
        repeat (2) cyc();
        expect_val(S_DMSTATUS,  32'h0, "rst_dmstatus");
        expect_val(S_HALTREQ,   32'h0, "rst_haltreq");
        expect_val(S_DMCONTROL, 32'h0, "rst_dmcontrol");
        check();
        rst = 1'b0;
        cyc();
        expect_val(S_DMSTATUS, ds(0,0,0,0,0,0,0,0,0,0,1,1), "post_rst_status");
        check();

        // Activate, then hartreset + ndmreset on hart0
        wr(A_CTRL, 32'h0000_0001);
        expect_val(S_DMACTIVE, 32'h1, "dmactive_set");
        check();
        wr(A_CTRL, 32'h2000_0003);
        expect_val(S_HARTRESET, 32'h1, "hartreset_h0");
        expect_val(S_NDMRESET,  32'h1, "ndmreset_set");
        expect_val(S_DMCONTROL, 32'h0000_0003, "ctrl_rd_w1_zero");
        check();
        wr(A_CTRL, 32'h0000_0001);
        expect_val(S_HARTRESET, 32'h0, "hartreset_clr");
        expect_val(S_NDMRESET,  32'h0, "ndmreset_clr");
        check();

        // Halt hart0
        halted = 4'b0001; running = 4'b1110;
        wr(A_CTRL, 32'h8000_0001);
        expect_val(S_HALTREQ, 32'h1, "haltreq_h0");
        check();
        cyc();
        expect_val(S_DMSTATUS, ds(1,1,0,0,0,0,0,0,0,0,1,1), "status_h0_halted");
        check();

        // Hart-array window
        wr(A_HWSEL, 32'h7);
        expect_val(S_HWSEL, 32'h0, "hwsel_clamp");
        check();
        wr(A_HW, 32'hFFFF_FFFA);
        expect_val(S_HAWINDOW, 32'hA, "hawindow_trim");
        check();
        wr(A_CTRL, 32'h8400_0001);
        expect_val(S_HALTREQ,   32'hB, "haltreq_hasel");
        expect_val(S_DMCONTROL, 32'h0400_0001, "ctrl_rd_hasel");
        check();

        // Resume with only hart1 halted
        halted = 4'b0010; running = 4'b1101;
        wr(A_CTRL, 32'h4400_0001);
        expect_val(S_RESUMEREQ, 32'h2, "resumereq_h1");
        expect_val(S_HALTREQ,   32'h0, "haltreq_dropped");
        check();
        cyc();
        expect_val(S_DMSTATUS, ds(1,0,1,0,0,0,0,0,0,0,1,1), "status_resuming");
        check();

        // Resume ack on hart1, spurious ack on hart0
        halted = 4'b0000; running = 4'b1111; resumeack_p = 4'b0011;
        cyc();
        resumeack_p = 4'b0000;
        expect_val(S_RESUMEREQ, 32'h0, "resumereq_acked");
        check();
        cyc();
        expect_val(S_DMSTATUS, ds(0,0,1,1,0,0,0,0,1,0,1,1), "status_resumeack");
        check();

        // Nonexistent hartsel (13 truncates to 5, hartselhi dropped)
        wr(A_CTRL, 32'h8001_0001);
        wr(A_CTRL, 32'h8002_0001);
        expect_val(S_HALTREQ, 32'h6, "haltreq_h1_h2");
        check();
        wr(A_CTRL, 32'h000D_0041);
        expect_val(S_HALTREQ,   32'h6, "haltreq_nonexist");
        expect_val(S_DMCONTROL, 32'h0005_0001, "hartsel_trunc");
        check();
        cyc();
        expect_val(S_DMSTATUS, ds(0,0,0,0,0,0,1,1,0,0,0,0), "status_nonexist");
        check();

        // ackhavereset racing a havereset pulse on hart2
        unavail = 4'b0100; havereset_p = 4'b0100;
        wr(A_CTRL, 32'h1002_0001);
        havereset_p = 4'b0000;
        expect_val(S_HALTREQ, 32'h2, "haltreq_h2_clr");
        check();
        cyc();
        expect_val(S_DMSTATUS, ds(0,0,1,1,1,1,0,0,0,0,1,1), "havereset_race");
        check();
        wr(A_CTRL, 32'h1002_0001);
        cyc();
        expect_val(S_DMSTATUS, ds(0,0,1,1,1,1,0,0,0,0,0,0), "havereset_acked");
        check();
        unavail = 4'b0000;

        // Deactivate mid-resume
        halted = 4'b0001; running = 4'b1110;
        wr(A_CTRL, 32'h4000_0001);
        expect_val(S_RESUMEREQ, 32'h1, "resumereq_h0");
        expect_val(S_HALTREQ,   32'h2, "haltreq_kept");
        expect_val(S_HAWINDOW,  32'hA, "hawindow_kept");
        check();
        wr(A_CTRL, 32'h0000_0000);
        expect_val(S_RESUMEREQ, 32'h0, "deact_resumereq");
        expect_val(S_HALTREQ,   32'h0, "deact_haltreq");
        expect_val(S_HAWINDOW,  32'h0, "deact_hawindow");
        expect_val(S_DMCONTROL, 32'h0, "deact_dmcontrol");
        check();
        wr(A_CTRL, 32'h8000_0001);
        expect_val(S_HALTREQ,   32'h0, "inactive_haltreq");
        expect_val(S_DMCONTROL, 32'h1, "inactive_only_da");
        check();
        cyc();
        expect_val(S_DMSTATUS, ds(1,1,0,0,0,0,0,0,0,0,1,1), "deact_status_h0");
        check();
        wr(A_CTRL, 32'h0002_0001);
        cyc();
        expect_val(S_DMSTATUS, ds(0,0,1,1,0,0,0,0,0,0,0,0), "deact_hr_h2_kept");
        check();
        wr(A_CTRL, 32'h0001_0001);
        cyc();
        expect_val(S_DMSTATUS, ds(0,0,1,1,0,0,0,0,0,0,1,1), "deact_rack_clr");
        check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
